// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Two-port round-robin arbiter and sequencer for a shared 16-bit
//            asynchronous SRAM. Each 32-bit request becomes two 16-bit SRAM
//            cycles (low half first). Each half lasts WAIT_CYCLES clocks.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 single clock; all state changes on the rising edge
//   rst                 asynchronous reset, active low
//   pX_rd_en/pX_wr_en   level requests; if both are set the access is a write
//   pX_addr/pX_wdata    byte address / write data, held while requesting
//   pX_rdata            last completed read for port X
//   pX_ready            combinational; low while port X waits for its access
//   SRAM_DQ             bidirectional SRAM data bus
//   SRAM_ADDR           registered half-word address
//   SRAM_WE_N           registered write enable, active low
//   grant               port owning the current or most recent access
//   busy                high whenever an access is in progress
// ============================================================================
module sram_arbiter #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_rd_en,
    input  logic        p0_wr_en,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_ready,
    input  logic        p1_rd_en,
    input  logic        p1_wr_en,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        grant,
    output logic        busy
);

    // Final count value of a half; the counter restarts at 0 on each phase.
    localparam logic [2:0] C_LAST_CNT = 3'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [2:0]  cnt_q,       cnt_d;
    logic        op_wr_q,     op_wr_d;
    logic [16:0] word_q,      word_d;
    logic [31:0] wdata_q,     wdata_d;
    logic        grant_q,     grant_d;
    logic        last_q,      last_d;
    logic [15:0] rd_lo_q,     rd_lo_d;
    logic [31:0] p0_rdata_q,  p0_rdata_d;
    logic [31:0] p1_rdata_q,  p1_rdata_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic        sram_we_n_q, sram_we_n_d;

    logic        w_req0;
    logic        w_req1;
    logic        w_sel;
    logic        w_last_cyc;
    logic        w_phase_d;
    logic        w_done;
    logic        w_dq_oe;
    logic [15:0] w_dq_out;
    logic [31:0] w_off0;
    logic [31:0] w_off1;
    logic        w_unused_addr_bits;

    assign w_req0 = p0_rd_en | p0_wr_en;
    assign w_req1 = p1_rd_en | p1_wr_en;

    // Wrap-around offset from the SRAM window base; only word bits [18:2]
    // reach the SRAM, everything above silently aliases.
    assign w_off0 = p0_addr - ADDR_BASE;
    assign w_off1 = p1_addr - ADDR_BASE;
    assign w_unused_addr_bits = ^{w_off0[31:19], w_off0[1:0],
                                  w_off1[31:19], w_off1[1:0]};

    assign w_last_cyc = (cnt_q == C_LAST_CNT);
    assign w_done     = (state_q == ST_DONE);

    // The bus is driven only while a write owns LO or HI; it is released in
    // DONE and IDLE, and immediately when reset clears the state register.
    assign w_dq_oe  = op_wr_q & ((state_q == ST_LO) | (state_q == ST_HI));
    assign w_dq_out = (state_q == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ  = w_dq_oe ? w_dq_out : 16'hzzzz;

    // Ready is forced high during reset so a frozen CPU is released.
    assign p0_ready = ~rst | ~w_req0 | (w_done & ~grant_q);
    assign p1_ready = ~rst | ~w_req1 | (w_done &  grant_q);

    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = sram_we_n_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        grant_d    = grant_q;
        last_d     = last_q;
        rd_lo_d    = rd_lo_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        w_sel      = last_q;

        case (state_q)
            ST_IDLE: begin
                if (w_req0 | w_req1) begin
                    // On a tie the port that did not win last time goes next.
                    w_sel   = (w_req0 & w_req1) ? ~last_q : w_req1;
                    state_d = ST_LO;
                    cnt_d   = 3'd0;
                    op_wr_d = w_sel ? p1_wr_en : p0_wr_en;
                    word_d  = w_sel ? w_off1[18:2] : w_off0[18:2];
                    wdata_d = w_sel ? p1_wdata : p0_wdata;
                    grant_d = w_sel;
                    last_d  = w_sel;
                end
            end
            ST_LO: begin
                if (w_last_cyc) begin
                    state_d = ST_HI;
                    cnt_d   = 3'd0;
                    if (!op_wr_q) begin
                        rd_lo_d = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_HI: begin
                if (w_last_cyc) begin
                    state_d = ST_DONE;
                    cnt_d   = 3'd0;
                    if (!op_wr_q) begin
                        if (grant_q) begin
                            p1_rdata_d = {SRAM_DQ, rd_lo_q};
                        end else begin
                            p0_rdata_d = {SRAM_DQ, rd_lo_q};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                // Always one idle cycle between accesses.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SRAM pins are registered, so they are computed from the state the
        // FSM is about to enter. WE_N returns high on the final cycle of each
        // half so address and data stay stable across its rising edge.
        w_phase_d   = (state_d == ST_LO) || (state_d == ST_HI);
        sram_addr_d = w_phase_d ? {word_d, state_d == ST_HI} : sram_addr_q;
        sram_we_n_d = ~(op_wr_d & w_phase_d & (cnt_d != C_LAST_CNT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            op_wr_q     <= 1'b0;
            word_q      <= 17'd0;
            wdata_q     <= 32'd0;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            rd_lo_q     <= 16'd0;
            p0_rdata_q  <= 32'd0;
            p1_rdata_q  <= 32'd0;
            sram_addr_q <= 18'd0;
            sram_we_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            rd_lo_q     <= rd_lo_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            sram_addr_q <= sram_addr_d;
            sram_we_n_q <= sram_we_n_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Self-checking bench for sram_arbiter. An access-level reference
//            model (age of the current access in cycles) predicts every
//            output each cycle. The bench also plays the SRAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int W        = 2;
    localparam int DONE_AGE = 2 * W + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_rd_en, p0_wr_en, p1_rd_en, p1_wr_en;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_ready, p1_ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, grant, busy;
    logic        tb_oe;
    logic [15:0] tb_dq;

    // Second build with single-cycle halves; only port 1 is exercised.
    logic        a_p0_rd_en, a_p0_wr_en, a_p1_rd_en, a_p1_wr_en;
    logic [31:0] a_p0_addr, a_p0_wdata, a_p1_addr, a_p1_wdata;
    logic [31:0] a_p0_rdata, a_p1_rdata;
    logic        a_p0_ready, a_p1_ready;
    wire  [15:0] a_sram_dq;
    logic [17:0] a_sram_addr;
    logic        a_sram_we_n, a_grant, a_busy;

    assign sram_dq = tb_oe ? tb_dq : 16'hzzzz;

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_BASE(32'd1024)) dut (
        .clk(clk), .rst(rst),
        .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ready(p0_ready),
        .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ready(p1_ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
        .grant(grant), .busy(busy)
    );

    sram_arbiter #(.WAIT_CYCLES(1), .ADDR_BASE(32'd1024)) dut_w1 (
        .clk(clk), .rst(rst),
        .p0_rd_en(a_p0_rd_en), .p0_wr_en(a_p0_wr_en), .p0_addr(a_p0_addr),
        .p0_wdata(a_p0_wdata), .p0_rdata(a_p0_rdata), .p0_ready(a_p0_ready),
        .p1_rd_en(a_p1_rd_en), .p1_wr_en(a_p1_wr_en), .p1_addr(a_p1_addr),
        .p1_wdata(a_p1_wdata), .p1_rdata(a_p1_rdata), .p1_ready(a_p1_ready),
        .SRAM_DQ(a_sram_dq), .SRAM_ADDR(a_sram_addr), .SRAM_WE_N(a_sram_we_n),
        .grant(a_grant), .busy(a_busy)
    );

    // ---------------- reference model state ----------------
    bit          m_active;
    int          m_age;          // 1..W low half, W+1..2W high half, 2W+1 done
    bit          m_owner, m_wr, m_last, m_grant;
    logic [16:0] m_word;
    logic [31:0] m_wdata;
    logic [17:0] m_addr;
    logic [31:0] m_rdata [2];
    logic [15:0] mem [int];

    int n_pass = 0;
    int n_total = 0;
    bit done0, done1, obs_rdy0, obs_rdy1;

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 16'(int'(a) * 40503) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_age = 0; m_owner = 1'b0; m_wr = 1'b0;
        m_last = 1'b1; m_grant = 1'b0; m_addr = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    // Advances the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit r0, r1, sel;
        logic [31:0] off;
        r0 = p0_rd_en | p0_wr_en;
        r1 = p1_rd_en | p1_wr_en;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_active) begin
            if (m_wr && m_age == W)     mem[int'({m_word, 1'b0})] = m_wdata[15:0];
            if (m_wr && m_age == 2 * W) mem[int'({m_word, 1'b1})] = m_wdata[31:16];
            if (!m_wr && m_age == 2 * W)
                m_rdata[m_owner] = {mem_rd({m_word, 1'b1}), mem_rd({m_word, 1'b0})};
            if (m_age == DONE_AGE) m_active = 1'b0;
            else m_age = m_age + 1;
        end else if (r0 || r1) begin
            sel      = (r0 && r1) ? ~m_last : r1;
            m_active = 1'b1;
            m_age    = 1;
            m_owner  = sel;
            m_last   = sel;
            m_grant  = sel;
            m_wr     = sel ? p1_wr_en : p0_wr_en;
            off      = (sel ? p1_addr : p0_addr) - 32'd1024;
            m_word   = off[18:2];
            m_wdata  = sel ? p1_wdata : p0_wdata;
        end
        if (m_active && m_age <= 2 * W) m_addr = {m_word, m_age > W};
    endtask

    // One clock: play the SRAM, compare every output, advance the model.
    // Entered and left at posedge+1, so inputs set by the caller are stable.
    task automatic cycle();
        bit r0, r1, dn, hiz;
        if (!rst) model_reset();
        tb_oe = m_active && !m_wr && m_age <= 2 * W;
        tb_dq = mem_rd({m_word, m_age > W});
        #2;
        r0 = p0_rd_en | p0_wr_en;
        r1 = p1_rd_en | p1_wr_en;
        dn = m_active && m_age == DONE_AGE;
        done0 = dn && !m_owner;
        done1 = dn && m_owner;
        chk("busy", busy, m_active);
        chk("grant", grant, m_grant);
        chk("p0_ready", p0_ready, !rst || !r0 || done0);
        chk("p1_ready", p1_ready, !rst || !r1 || done1);
        chk("sram_addr", sram_addr, m_addr);
        chk("we_n", sram_we_n,
            !(m_active && m_wr && m_age <= 2 * W && m_age != W && m_age != 2 * W));
        if (m_active && m_wr && m_age <= 2 * W) begin
            chk("dq_wdata", sram_dq, (m_age > W) ? m_wdata[31:16] : m_wdata[15:0]);
        end else if (!tb_oe) begin
            hiz = (sram_dq === 16'hzzzz) || (sram_dq === 16'h0000);
            chk("dq_hiz", hiz, 1'b1);
        end
        chk("p0_rdata", p0_rdata, m_rdata[0]);
        chk("p1_rdata", p1_rdata, m_rdata[1]);
        obs_rdy0 = p0_ready;
        obs_rdy1 = p1_ready;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit port, output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            lat = lat + 1;
            if (port ? obs_rdy1 : obs_rdy0) return;
        end
    endtask

    task automatic rand_req(output logic rd, output logic wr,
                            output logic [31:0] a, output logic [31:0] d);
        int mode;
        mode = $urandom_range(0, 2);
        rd   = (mode != 1);
        wr   = (mode != 0);
        if ($urandom_range(0, 9) == 0) a = 32'd1024 - 4 * $urandom_range(1, 8);
        else a = 32'd1024 + 4 * $urandom_range(0, 63);
        d = $urandom;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, lat1, guard;
        logic hz;
        rst = 1'b0; tb_oe = 1'b0; tb_dq = '0;
        p0_rd_en = 0; p0_wr_en = 0; p0_addr = '0; p0_wdata = '0;
        p1_rd_en = 0; p1_wr_en = 0; p1_addr = '0; p1_wdata = '0;
        a_p0_rd_en = 0; a_p0_wr_en = 0; a_p0_addr = '0; a_p0_wdata = '0;
        a_p1_rd_en = 0; a_p1_wr_en = 0; a_p1_addr = '0; a_p1_wdata = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state, with a pending request that must still see ready=1.
        cycle();
        p0_rd_en = 1;
        cycle();
        p0_rd_en = 0;
        rst = 1'b1;
        cycle();

        // Read at 1024+8: half-words 4 and 5.
        mem[4] = 16'hBEEF;
        mem[5] = 16'h1234;
        p0_addr = 32'd1032; p0_rd_en = 1;
        wait_ready(1'b0, lat);
        p0_rd_en = 0;
        chk("t1_latency", lat, 32'd6);
        chk("t1_rdata", p0_rdata, 32'h1234BEEF);
        cycle();

        // Write 0xCAFE0001 at 1028: half-words 2 and 3; rdata untouched.
        p0_addr = 32'd1028; p0_wdata = 32'hCAFE0001; p0_wr_en = 1;
        wait_ready(1'b0, lat);
        p0_wr_en = 0;
        chk("t2_latency", lat, 32'd6);
        chk("t2_rdata_kept", p0_rdata, 32'h1234BEEF);
        cycle();

        // Simultaneous reads straight out of reset: port 0 first.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        p0_addr = 32'd1040; p0_rd_en = 1;
        p1_addr = 32'd1100; p1_rd_en = 1;
        wait_ready(1'b0, lat);
        p0_rd_en = 0;
        wait_ready(1'b1, lat1);
        p1_rd_en = 0;
        chk("t3_p0_latency", lat, 32'd6);
        chk("t3_p1_gap", lat1, 32'd6);
        cycle();
        p0_rd_en = 1; p1_rd_en = 1;
        cycle();
        chk("t3_second_pair_grant", grant, 32'd0);
        wait_ready(1'b0, lat);
        p0_rd_en = 0;
        wait_ready(1'b1, lat1);
        p1_rd_en = 0;
        cycle();

        // Port 1 holds continuously, port 0 re-requests back to back.
        p0_addr = 32'd1200; p0_rd_en = 1;
        p1_addr = 32'd1300; p1_rd_en = 1;
        for (int k = 0; k < 4; k++) begin
            guard = 0;
            while (busy !== 1'b1 && guard < 20) begin
                cycle();
                guard = guard + 1;
            end
            chk("t4_alternating_grant", grant, k % 2);
            guard = 0;
            while (busy === 1'b1 && guard < 20) begin
                cycle();
                if (done0) p0_addr = p0_addr + 4;
                guard = guard + 1;
            end
        end
        p0_rd_en = 0; p1_rd_en = 0;
        cycle();

        // Reset in the high half of a write.
        p0_addr = 32'd1060; p0_wdata = 32'h89AB4321; p0_wr_en = 1;
        cycle();
        cycle();
        cycle();
        chk("t5_in_hi_we_n", sram_we_n, 1'b0);
        rst = 1'b0;
        #1;
        hz = (sram_dq === 16'hzzzz) || (sram_dq === 16'h0000);
        chk("t5_rst_we_n", sram_we_n, 1'b1);
        chk("t5_rst_dq_hiz", hz, 1'b1);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_ready", p0_ready, 1'b1);
        cycle();
        rst = 1'b1; p0_wr_en = 0;
        cycle();
        p0_rd_en = 1;
        wait_ready(1'b0, lat);
        p0_rd_en = 0;
        chk("t5_after_latency", lat, 32'd6);
        chk("t5_partial_low", p0_rdata[15:0], 32'h4321);
        cycle();

        // Randomized traffic, including mid-access drops and wrapped addresses.
        for (int i = 0; i < 400; i++) begin
            if (!(p0_rd_en | p0_wr_en) && $urandom_range(0, 2) == 0)
                rand_req(p0_rd_en, p0_wr_en, p0_addr, p0_wdata);
            if (!(p1_rd_en | p1_wr_en) && $urandom_range(0, 2) == 0)
                rand_req(p1_rd_en, p1_wr_en, p1_addr, p1_wdata);
            cycle();
            if (done0 || $urandom_range(0, 24) == 0) begin
                p0_rd_en = 0; p0_wr_en = 0;
            end
            if (done1 || $urandom_range(0, 24) == 0) begin
                p1_rd_en = 0; p1_wr_en = 0;
            end
        end
        p0_rd_en = 0; p0_wr_en = 0; p1_rd_en = 0; p1_wr_en = 0;
        for (int i = 0; i < 8; i++) cycle();

        // Single-wait build: both enables means write; ready three cycles on.
        a_p1_addr = 32'd1036; a_p1_wdata = 32'h5A5AA5A5;
        a_p1_rd_en = 1; a_p1_wr_en = 1;
        #1;
        chk("t6_idle_ready", a_p1_ready, 1'b0);
        chk("t6_idle_busy", a_busy, 1'b0);
        @(posedge clk); #2;
        chk("t6_lo_addr", a_sram_addr, 18'd6);
        chk("t6_lo_dq", a_sram_dq, 16'hA5A5);
        chk("t6_lo_we_n", a_sram_we_n, 1'b1);
        chk("t6_lo_ready", a_p1_ready, 1'b0);
        @(posedge clk); #2;
        chk("t6_hi_addr", a_sram_addr, 18'd7);
        chk("t6_hi_dq", a_sram_dq, 16'h5A5A);
        chk("t6_hi_ready", a_p1_ready, 1'b0);
        @(posedge clk); #2;
        chk("t6_done_ready", a_p1_ready, 1'b1);
        chk("t6_done_grant", a_grant, 1'b1);
        hz = (a_sram_dq === 16'hzzzz) || (a_sram_dq === 16'h0000);
        chk("t6_done_dq_hiz", hz, 1'b1);
        a_p1_rd_en = 0; a_p1_wr_en = 0;
        @(posedge clk); #2;
        chk("t6_idle_after", a_busy, 1'b0);
        chk("t6_rdata_unchanged", a_p1_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
